// File: rtl/cnn_pkg.sv
// ============================================================================
// Module      : cnn_pkg
// Description : Shared width helpers, activation/saturation functions and
//               stage tag type for the CNN datapath blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

    // Valid bit plus first/last channel tags that ride along each pipeline stage
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } stage_tag_t;

    function automatic int m_bw(input int i_f_bw, input int w_bw);
        return i_f_bw + w_bw + 1;
    endfunction

    function automatic int ak_bw(input int mbw, input int n_terms);
        return mbw + $clog2(n_terms);
    endfunction

    function automatic int ac_bw(input int akbw, input int ci);
        return akbw + $clog2(ci) + 1;
    endfunction

    function automatic int idx(input int y, input int x, input int kx);
        return y * kx + x;
    endfunction

    function automatic logic signed [63:0] relu(input logic signed [63:0] v, input bit en);
        return (en && (v < 0)) ? 64'sd0 : v;
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int bw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cnn_adder_tree.sv
// ============================================================================
// Module      : cnn_adder_tree
// Description : Sign-extending reduction of N packed signed terms into one
//               registered sum, updated only when enabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_adder_tree #(
    parameter int N      = 25,
    parameter int IN_BW  = 17,
    parameter int OUT_BW = IN_BW + $clog2(N)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_en,
    input  logic [N*IN_BW-1:0]       i_data,
    output logic signed [OUT_BW-1:0] o_sum
);

    logic signed [OUT_BW-1:0] w_sum;
    logic signed [OUT_BW-1:0] r_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = w_sum + OUT_BW'($signed(i_data[i*IN_BW +: IN_BW]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_sum <= '0;
        else if (i_en)
            r_sum <= w_sum;
    end

    assign o_sum = r_sum;

endmodule

`default_nettype wire

// File: rtl/cnn_kernel_mc.sv
// ============================================================================
// Module      : cnn_kernel_mc
// Description : Multi-input-channel KXxKY convolution kernel: per-beat MAC,
//               CI-beat accumulation, bias, optional ReLU, saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_kernel_mc
    import cnn_pkg::*;
#(
    parameter int KX       = 5,
    parameter int KY       = 5,
    parameter int CI       = 3,
    parameter int I_F_BW   = 8,
    parameter int W_BW     = 8,
    parameter int B_BW     = 16,
    parameter int O_BW     = 16,
    parameter int USE_RELU = 1,
    localparam int CH_W    = (CI > 1) ? $clog2(CI) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_soft_clr,
    input  logic [KX*KY*W_BW-1:0]   i_cnn_weight,
    input  logic [B_BW-1:0]         i_cnn_bias,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [KX*KY*I_F_BW-1:0] i_in_fmap,
    output logic                    o_ot_valid,
    input  logic                    i_ot_ready,
    output logic [O_BW-1:0]         o_ot_data,
    output logic [CH_W-1:0]         o_ch_idx
);

    localparam int N     = KX * KY;
    localparam int M_BW  = m_bw(I_F_BW, W_BW);
    localparam int AK_BW = ak_bw(M_BW, N);
    localparam int AC_BW = ac_bw(AK_BW, CI);
    localparam int Y_BW  = ((AC_BW > B_BW) ? AC_BW : B_BW) + 1;

    logic                     w_adv;
    logic                     w_accept;
    logic                     w_first;
    logic                     w_last;
    logic [N*M_BW-1:0]        w_prod;
    logic signed [AK_BW-1:0]  w_s2_sum;
    logic signed [Y_BW-1:0]   w_y;

    logic [CH_W-1:0]          r_ch;
    stage_tag_t               r_s1;
    stage_tag_t               r_s2;
    logic                     r_s3_vld;
    logic                     r_s3_last;
    logic [N*M_BW-1:0]        r_s1_prod;
    logic signed [B_BW-1:0]   r_s1_bias;
    logic signed [B_BW-1:0]   r_s2_bias;
    logic signed [B_BW-1:0]   r_s3_bias;
    logic signed [AC_BW-1:0]  r_acc;
    logic                     r_ot_valid;
    logic [O_BW-1:0]          r_ot_data;

    // The whole pipeline moves in lockstep with the output register
    assign w_adv    = !r_ot_valid || i_ot_ready;
    assign w_accept = i_in_valid && w_adv && !i_soft_clr;
    assign w_first  = (r_ch == '0);
    assign w_last   = (r_ch == CH_W'(CI - 1));

    for (genvar gy = 0; gy < KY; gy++) begin : g_row
        for (genvar gx = 0; gx < KX; gx++) begin : g_col
            localparam int c_idx = idx(gy, gx, KX);
            // Feature is unsigned: a leading zero keeps it positive in the signed multiply
            assign w_prod[c_idx*M_BW +: M_BW] =
                M_BW'($signed({1'b0, i_in_fmap[c_idx*I_F_BW +: I_F_BW]})) *
                M_BW'($signed(i_cnn_weight[c_idx*W_BW +: W_BW]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ch      <= '0;
            r_s1      <= '0;
            r_s1_prod <= '0;
            r_s1_bias <= '0;
        end else if (i_soft_clr) begin
            r_ch      <= '0;
            r_s1      <= '0;
        end else if (w_adv) begin
            r_s1.vld <= w_accept;
            if (w_accept) begin
                r_s1.first <= w_first;
                r_s1.last  <= w_last;
                r_s1_prod  <= w_prod;
                r_ch       <= w_last ? '0 : r_ch + CH_W'(1);
                if (w_last)
                    r_s1_bias <= $signed(i_cnn_bias);
            end
        end
    end

    cnn_adder_tree #(
        .N      (N),
        .IN_BW  (M_BW),
        .OUT_BW (AK_BW)
    ) u_tree (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_adv && r_s1.vld && !i_soft_clr),
        .i_data (r_s1_prod),
        .o_sum  (w_s2_sum)
    );

    assign w_y = Y_BW'(r_acc) + Y_BW'(r_s3_bias);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2       <= '0;
            r_s2_bias  <= '0;
            r_s3_vld   <= 1'b0;
            r_s3_last  <= 1'b0;
            r_s3_bias  <= '0;
            r_acc      <= '0;
            r_ot_valid <= 1'b0;
            r_ot_data  <= '0;
        end else if (i_soft_clr) begin
            r_s2       <= '0;
            r_s3_vld   <= 1'b0;
            r_s3_last  <= 1'b0;
            r_acc      <= '0;
            r_ot_valid <= 1'b0;
        end else if (w_adv) begin
            r_s2      <= r_s1;
            r_s2_bias <= r_s1_bias;
            r_s3_vld  <= r_s2.vld;
            // Bubbles leave the running channel sum untouched
            if (r_s2.vld) begin
                r_s3_last <= r_s2.last;
                r_s3_bias <= r_s2_bias;
                r_acc     <= (r_s2.first ? '0 : r_acc) + AC_BW'(w_s2_sum);
            end
            r_ot_valid <= r_s3_vld && r_s3_last;
            if (r_s3_vld && r_s3_last)
                r_ot_data <= O_BW'(sat_signed(relu(64'(w_y), USE_RELU != 0), O_BW));
        end
    end

    assign o_in_ready = w_adv;
    assign o_ot_valid = r_ot_valid;
    assign o_ot_data  = r_ot_data;
    assign o_ch_idx   = r_ch;

endmodule

`default_nettype wire

// File: tb/tb_cnn_kernel_mc.sv
// ============================================================================
// Module      : tb_cnn_kernel_mc
// Description : Self-checking bench for cnn_kernel_mc with ReLU and non-ReLU
//               instances sharing one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_kernel_mc;

    localparam int KX = 5, KY = 5, CI = 3, N = KX * KY;
    localparam int IFB = 8, WB = 8, BB = 16, OB = 16, CHW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic i_soft_clr = 1'b0;
    logic i_in_valid = 1'b0;
    logic i_ot_ready = 1'b1;
    logic [N*WB-1:0]  i_cnn_weight = '0;
    logic [BB-1:0]    i_cnn_bias = '0;
    logic [N*IFB-1:0] i_in_fmap = '0;
    logic             o_in_ready, o_ot_valid, nr_in_ready, nr_ot_valid;
    logic [OB-1:0]    o_ot_data, nr_ot_data;
    logic [CHW-1:0]   o_ch_idx, nr_ch_idx;

    int n_cmp = 0;
    int n_fail = 0;
    int n_out = 0;

    typedef struct {
        longint r;
        longint nr;
    } exp_t;
    exp_t   exp_q[$];
    longint psum = 0;
    int     part_n = 0;

    typedef struct {
        logic [7:0]         f;
        logic signed [7:0]  w;
        logic signed [15:0] b;
        bit                 single;
        longint             exp_r;
        longint             exp_nr;
    } vec_t;
    vec_t vecs[9];

    always #5 clk = ~clk;

    cnn_kernel_mc #(.KX(KX), .KY(KY), .CI(CI), .I_F_BW(IFB), .W_BW(WB),
                    .B_BW(BB), .O_BW(OB), .USE_RELU(1)) dut (
        .clk(clk), .reset(reset), .i_soft_clr(i_soft_clr),
        .i_cnn_weight(i_cnn_weight), .i_cnn_bias(i_cnn_bias),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_fmap(i_in_fmap),
        .o_ot_valid(o_ot_valid), .i_ot_ready(i_ot_ready),
        .o_ot_data(o_ot_data), .o_ch_idx(o_ch_idx));

    cnn_kernel_mc #(.KX(KX), .KY(KY), .CI(CI), .I_F_BW(IFB), .W_BW(WB),
                    .B_BW(BB), .O_BW(OB), .USE_RELU(0)) dut_nr (
        .clk(clk), .reset(reset), .i_soft_clr(i_soft_clr),
        .i_cnn_weight(i_cnn_weight), .i_cnn_bias(i_cnn_bias),
        .i_in_valid(i_in_valid), .o_in_ready(nr_in_ready), .i_in_fmap(i_in_fmap),
        .o_ot_valid(nr_ot_valid), .i_ot_ready(i_ot_ready),
        .o_ot_data(nr_ot_data), .o_ch_idx(nr_ch_idx));

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    function automatic longint sat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint dot(input logic [N*IFB-1:0] f, input logic [N*WB-1:0] w);
        longint s = 0;
        for (int i = 0; i < N; i++)
            s += longint'(f[i*IFB +: IFB]) * longint'($signed(w[i*WB +: WB]));
        return s;
    endfunction

    // Reference model: per accepted beat add the channel dot product; every CI beats emit a result
    initial forever begin
        @(negedge clk);
        if (reset) begin
            part_n = 0;
            psum = 0;
            exp_q.delete();
        end else begin
            check("ch_idx", o_ch_idx, part_n);
            if (o_ot_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_result: got %0d, expected no result", $signed(o_ot_data));
                end else begin
                    check("data_relu", $signed(o_ot_data), exp_q[0].r);
                    check("data_norelu", $signed(nr_ot_data), exp_q[0].nr);
                    if (i_ot_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (i_soft_clr) begin
                part_n = 0;
                psum = 0;
                exp_q.delete();
            end else if (i_in_valid && o_in_ready) begin
                psum += dot(i_in_fmap, i_cnn_weight);
                part_n++;
                if (part_n == CI) begin
                    longint y;
                    exp_t e;
                    y = psum + longint'($signed(i_cnn_bias));
                    e.r = sat((y < 0) ? 0 : y);
                    e.nr = sat(y);
                    exp_q.push_back(e);
                    part_n = 0;
                    psum = 0;
                end
            end
        end
    end

    task automatic set_beat(input logic [7:0] f, input logic signed [7:0] w,
                            input logic signed [15:0] b, input bit single);
        for (int i = 0; i < N; i++) begin
            i_in_fmap[i*IFB +: IFB]  = (single && i != 0) ? 8'd0 : f;
            i_cnn_weight[i*WB +: WB] = (single && i != 0) ? 8'd0 : w;
        end
        i_cnn_bias = b;
        i_in_valid = 1'b1;
    endtask

    // Call just after a rising edge; returns just after the edge that accepted the beat
    task automatic send_beat(input logic [7:0] f, input logic signed [7:0] w,
                             input logic signed [15:0] b, input bit single);
        bit took = 1'b0;
        set_beat(f, w, b, single);
        for (int k = 0; k < 50 && !took; k++) begin
            @(negedge clk);
            took = o_in_ready && !i_soft_clr;
            @(posedge clk);
            #1;
        end
        if (!took) fail_now("send_beat");
        i_in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!o_ot_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!o_ot_valid) fail_now("wait_valid");
    endtask

    initial begin
        int lat;
        int cnt;
        int n0;
        int accepted;
        int cycles;
        bit took;

        vecs[0] = '{8'd1,   8'sd1,    16'sd0,      1'b0, 75,    75};
        vecs[1] = '{8'd255, -8'sd128, 16'sd0,      1'b0, 0,     -32768};
        vecs[2] = '{8'd255, 8'sd127,  16'sd1000,   1'b0, 32767, 32767};
        vecs[3] = '{8'd2,   8'sd3,    -16'sd10,    1'b1, 8,     8};
        vecs[4] = '{8'd0,   8'sd5,    -16'sd5,     1'b0, 0,     -5};
        vecs[5] = '{8'd10,  -8'sd1,   16'sd800,    1'b0, 50,    50};
        vecs[6] = '{8'd200, 8'sd100,  -16'sd32768, 1'b0, 32767, 32767};
        vecs[7] = '{8'd255, -8'sd128, 16'sd100,    1'b1, 0,     -32768};
        vecs[8] = '{8'd3,   -8'sd4,   16'sd200,    1'b0, 0,     -700};

        // Reset / idle
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ot_valid", o_ot_valid, 0);
        check("rst_ot_data", o_ot_data, 0);
        check("rst_in_ready", o_in_ready, 1);
        check("rst_ch_idx", o_ch_idx, 0);
        @(posedge clk);
        #1;

        // Partial sums in flight must vanish with a mid-operation reset
        send_beat(8'd50, 8'sd50, 16'sd0, 1'b0);
        send_beat(8'd50, 8'sd50, 16'sd0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[v]) begin
            for (int c = 0; c < CI; c++)
                send_beat(vecs[v].f, vecs[v].w, vecs[v].b, vecs[v].single);
            wait_valid(lat);
            check($sformatf("vec%0d_latency", v), lat, 4);
            check($sformatf("vec%0d_relu", v), $signed(o_ot_data), vecs[v].exp_r);
            check($sformatf("vec%0d_norelu", v), $signed(nr_ot_data), vecs[v].exp_nr);
        end
        @(posedge clk);
        #1;

        // Backpressure: result held while further beats are offered
        i_ot_ready = 1'b0;
        for (int c = 0; c < CI; c++)
            send_beat(8'd1, 8'sd2, 16'sd0, 1'b0);
        set_beat(8'd1, 8'sd1, 16'sd0, 1'b0);
        wait_valid(lat);
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", o_in_ready, 0);
            check("bp_data", $signed(o_ot_data), 150);
        end
        @(posedge clk);
        #1 i_ot_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1 i_in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("bp_drain", exp_q.size(), 0);
        i_soft_clr = 1'b1;
        @(posedge clk);
        #1 i_soft_clr = 1'b0;

        // Flush: two stale channels dropped, only the fresh window counts
        send_beat(8'd9, 8'sd9, 16'sd0, 1'b0);
        send_beat(8'd9, 8'sd9, 16'sd0, 1'b0);
        i_soft_clr = 1'b1;
        @(posedge clk);
        #1 i_soft_clr = 1'b0;
        @(negedge clk);
        check("flush_ch_idx", o_ch_idx, 0);
        @(posedge clk);
        #1;
        for (int c = 0; c < CI; c++)
            send_beat(8'd1, 8'sd1, 16'sd0, 1'b0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_ot_valid) begin
                cnt++;
                check("flush_data", $signed(o_ot_data), 75);
            end
        end
        check("flush_count", cnt, 1);
        @(posedge clk);
        #1;

        // Random windows with random valid/ready against the model
        n0 = n_out;
        accepted = 0;
        cycles = 0;
        while (accepted < 100 * CI && cycles < 5000) begin
            if (!i_in_valid && $urandom_range(9) < 7) begin
                for (int i = 0; i < N; i++) begin
                    i_in_fmap[i*IFB +: IFB]  = 8'($urandom_range(255)) >> $urandom_range(7);
                    i_cnn_weight[i*WB +: WB] = $signed(8'($urandom_range(255))) >>> $urandom_range(7);
                end
                i_cnn_bias = 16'($urandom_range(65535));
                i_in_valid = 1'b1;
            end
            i_ot_ready = ($urandom_range(9) < 7);
            @(negedge clk);
            took = i_in_valid && o_in_ready;
            @(posedge clk);
            #1;
            cycles++;
            if (took) begin
                accepted++;
                i_in_valid = 1'b0;
            end
        end
        if (accepted < 100 * CI) fail_now("random_accept");
        i_in_valid = 1'b0;
        i_ot_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rand_results", n_out - n0, 100);
        check("rand_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
